multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Registered, multi-cycle successor to the combinational instruction decoder for the accumulator-style ISA.
- Latches one instruction per handshake and sequences FETCH/DECODE/MEM/WB.
- Drives single-cycle-qualified control strobes to the register file, ALU, condition-bit (CB) register, data memory and PC.
- Adds a memory request/acknowledge handshake with timeout, a sticky halt, and a sticky error. Register-address width and the accumulator index are parametrised.

Parameters:
REG_ADDR_W, 3, register-address width; instruction width INSTR_W = 5 + REG_ADDR_W.
ACC_ADDR, 7, accumulator register index (implicit rt / set target).
MEM_TIMEOUT, 15, max cycles in MEM without mem_ack_i before ERROR (>=1).

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous active-high reset
instr_i  in  INSTR_W  instruction word; opcode = instr_i[INSTR_W-1:INSTR_W-5], reg field r = instr_i[REG_ADDR_W-1:0]
instr_valid_i  in  1  instr_i valid
instr_ready_o  out  1  FSM accepts instruction (FETCH state)
cb_i  in  1  condition bit
alucontrol_o  out  4  ALU op, held from DECODE through WB
rs_addr_o  out  REG_ADDR_W  source register
rt_addr_o  out  REG_ADDR_W  second source register
write_addr_o  out  REG_ADDR_W  destination register
immediate_o  out  5  set-instruction immediate
write_data_control_o  out  1  1 = writeback from memory, 0 = from ALU
regwrite_o  out  1  one-cycle register write strobe
CBwrite_o  out  1  one-cycle CB write strobe
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  1 = store, 0 = load; valid with mem_req_o
mem_ack_i  in  1  memory done
branchf_o  out  1  one-cycle forward-branch strobe
branchb_o  out  1  one-cycle backward-branch strobe
pc_advance_o  out  1  one-cycle PC+1 strobe
done_o  out  1  sticky halt
err_o  out  1  sticky memory-timeout error

Behaviour:
- Reset, asynchronous, any state: state=FETCH; all outputs 0; instruction register 0; timeout counter 0.
- All outputs are registered or derived from state only. No combinational path from instr_i or cb_i to any output.
- FETCH:
  - instr_ready_o=1.
  - When instr_valid_i=1: latch instr_i, go to DECODE. Otherwise stay.
- DECODE:
  - Set alucontrol/rs/rt/write_addr/immediate/write_data_control from the latched word.
  - Sample cb_i into a branch-taken flag.
  - Next state: load/store go to MEM; halt goes to HALT; all others go to WB.
- Opcode table, field mapping and ALU code:
  - 00??? and: ALU 0000, wa=instr[REG_ADDR_W+2:3] (3-bit field), rs=r, rt=ACC.
  - 01??? add: ALU 0001, same fields as and.
  - 110?? set: ALU 1000, imm=instr[4:0], wa=ACC.
  - 11100 sll: ALU 0010, wa=rs=r, rt=ACC.
  - 11101 srl: ALU 0011, wa=rs=r.
  - 11110 branchf: rs=r, no write.
  - 11111 subsigned: ALU 0100, rs=2, rt=5, wa=r.
  - 10000 slt: ALU 0101, rs=6, rt=ACC, CB write.
  - 10001 halt.
  - 10010 load: wa=r, rt=ACC, write_data_control=1.
  - 10011 store: rs=r, rt=ACC.
  - 10100 abs: ALU 0110, wa=rs=r.
  - 10101 seq: ALU 0111, rs=r, rt=ACC, CB write.
  - 10110 branchb: rs=r.
  - 10111 reserved: NOP.
  - Fields not listed for an opcode drive 0.
- MEM:
  - mem_req_o=1; mem_we_o=1 for store, 0 for load. Both held stable until mem_ack_i.
  - Counter increments each cycle without ack.
  - mem_ack_i=1 goes to WB and clears the counter.
  - Counter reaching MEM_TIMEOUT without ack goes to ERROR. Ack on the same cycle as the counter reaching MEM_TIMEOUT wins.
- WB, exactly one cycle, then FETCH:
  - pc_advance_o=1 for every non-branch instruction, and for a branch that is not taken.
  - regwrite_o=1 for and/add/set/sll/srl/subsigned/load/abs.
  - CBwrite_o=1 for slt/seq.
  - branchf_o or branchb_o = sampled cb flag, for the corresponding opcode; pc_advance_o=0 when taken.
- HALT: done_o=1, instr_ready_o=0, all strobes 0. Exits only on reset.
- ERROR: err_o=1; otherwise same as HALT.
- Latency from accept edge: 3 cycles for non-memory ops (FETCH, DECODE, WB); 3+N for memory ops, where N = MEM cycles (>=1).
- Strobes never overlap instr_ready_o.
- Reset mid-MEM drops mem_req_o immediately and asynchronously.

Test Plan:
- Reset, then instr_i=8'b01_010_011 (add) with valid: DECODE shows alucontrol_o=0001, rs=3, rt=7, write_addr=2; next cycle regwrite_o=1 and pc_advance_o=1 for one cycle; back in FETCH with instr_ready_o=1.
- Load 8'b10010_101, mem_ack_i after 3 cycles: mem_req_o=1 and mem_we_o=0 for 3 cycles; WB has regwrite_o=1, write_data_control_o=1, write_addr_o=5.
- Store, mem_ack_i never asserted, MEM_TIMEOUT=15: after 15 MEM cycles err_o=1 sticky and instr_ready_o=0; after reset, err_o=0.
- branchf 11110_001 with cb_i=1 at DECODE then cb_i=0: branchf_o=1 and pc_advance_o=0 in WB. Repeat with cb_i=0 at DECODE: branchf_o=0, pc_advance_o=1.
- Halt 10001_000: done_o=1 from the cycle after DECODE. instr_valid_i held at 1 causes no acceptance. Asynchronous reset mid-cycle clears done_o without waiting for a clock edge.
- REG_ADDR_W=4, ACC_ADDR=15: seq 10101_1010 gives rs=10, rt=15, and CBwrite_o=1 in WB.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the accumulator ISA: accepts one instruction
// per handshake and walks it through FETCH/DECODE/MEM/WB with registered strobes.
module multicycle_control_fsm #(
  parameter int REG_ADDR_W  = 3,
  parameter int ACC_ADDR    = 7,
  parameter int MEM_TIMEOUT = 15,
  localparam int INSTR_W    = 5 + REG_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [INSTR_W-1:0]    instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic                  cb_i,
  output logic [3:0]            alucontrol_o,
  output logic [REG_ADDR_W-1:0] rs_addr_o,
  output logic [REG_ADDR_W-1:0] rt_addr_o,
  output logic [REG_ADDR_W-1:0] write_addr_o,
  output logic [4:0]            immediate_o,
  output logic                  write_data_control_o,
  output logic                  regwrite_o,
  output logic                  CBwrite_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  input  logic                  mem_ack_i,
  output logic                  branchf_o,
  output logic                  branchb_o,
  output logic                  pc_advance_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_WB, S_HALT, S_ERROR} state_t;

  localparam logic [4:0] OP_SLT   = 5'b10000;
  localparam logic [4:0] OP_HALT  = 5'b10001;
  localparam logic [4:0] OP_LOAD  = 5'b10010;
  localparam logic [4:0] OP_STORE = 5'b10011;
  localparam logic [4:0] OP_ABS   = 5'b10100;
  localparam logic [4:0] OP_SEQ   = 5'b10101;
  localparam logic [4:0] OP_BRB   = 5'b10110;
  localparam logic [4:0] OP_SLL   = 5'b11100;
  localparam logic [4:0] OP_SRL   = 5'b11101;
  localparam logic [4:0] OP_BRF   = 5'b11110;
  localparam logic [4:0] OP_SUBS  = 5'b11111;

  localparam logic [REG_ADDR_W-1:0] ACC = REG_ADDR_W'(ACC_ADDR);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t                  state;
  logic [4:0]              op_q;
  logic [CNT_W-1:0]        mem_cnt;
  logic [4:0]              in_op;
  logic [REG_ADDR_W-1:0]   in_r;
  logic [3:0]              dec_alu;
  logic [REG_ADDR_W-1:0]   dec_rs, dec_rt, dec_wa;
  logic [4:0]              dec_imm;
  logic                    dec_wdc;
  logic                    writes_reg;
  logic                    is_cb_write;

  assign in_op = instr_i[INSTR_W-1 -: 5];
  assign in_r  = instr_i[REG_ADDR_W-1:0];

  // Field decode of the incoming word; only ever captured into registers on accept.
  always_comb begin
    dec_alu = 4'b0000;
    dec_rs  = '0;
    dec_rt  = '0;
    dec_wa  = '0;
    dec_imm = '0;
    dec_wdc = 1'b0;
    casez (in_op)
      5'b00???: begin dec_alu = 4'b0000; dec_wa = instr_i[REG_ADDR_W+2:3]; dec_rs = in_r; dec_rt = ACC; end
      5'b01???: begin dec_alu = 4'b0001; dec_wa = instr_i[REG_ADDR_W+2:3]; dec_rs = in_r; dec_rt = ACC; end
      5'b110??: begin dec_alu = 4'b1000; dec_imm = instr_i[4:0]; dec_wa = ACC; end
      OP_SLL:   begin dec_alu = 4'b0010; dec_wa = in_r; dec_rs = in_r; dec_rt = ACC; end
      OP_SRL:   begin dec_alu = 4'b0011; dec_wa = in_r; dec_rs = in_r; end
      OP_BRF:   dec_rs = in_r;
      OP_SUBS:  begin dec_alu = 4'b0100; dec_rs = REG_ADDR_W'(2); dec_rt = REG_ADDR_W'(5); dec_wa = in_r; end
      OP_SLT:   begin dec_alu = 4'b0101; dec_rs = REG_ADDR_W'(6); dec_rt = ACC; end
      OP_LOAD:  begin dec_wa = in_r; dec_rt = ACC; dec_wdc = 1'b1; end
      OP_STORE: begin dec_rs = in_r; dec_rt = ACC; end
      OP_ABS:   begin dec_alu = 4'b0110; dec_wa = in_r; dec_rs = in_r; end
      OP_SEQ:   begin dec_alu = 4'b0111; dec_rs = in_r; dec_rt = ACC; end
      OP_BRB:   dec_rs = in_r;
      default:  ;
    endcase
  end

  assign writes_reg  = (op_q[4] == 1'b0) || (op_q[4:2] == 3'b110) ||
                       (op_q inside {OP_SLL, OP_SRL, OP_SUBS, OP_ABS});
  assign is_cb_write = (op_q == OP_SLT) || (op_q == OP_SEQ);

  // Single sequencer: strobes default low every cycle so each is asserted for WB only.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state                <= S_FETCH;
      op_q                 <= '0;
      mem_cnt              <= '0;
      instr_ready_o        <= 1'b0;
      alucontrol_o         <= '0;
      rs_addr_o            <= '0;
      rt_addr_o            <= '0;
      write_addr_o         <= '0;
      immediate_o          <= '0;
      write_data_control_o <= 1'b0;
      regwrite_o           <= 1'b0;
      CBwrite_o            <= 1'b0;
      mem_req_o            <= 1'b0;
      mem_we_o             <= 1'b0;
      branchf_o            <= 1'b0;
      branchb_o            <= 1'b0;
      pc_advance_o         <= 1'b0;
      done_o               <= 1'b0;
      err_o                <= 1'b0;
    end else begin
      regwrite_o   <= 1'b0;
      CBwrite_o    <= 1'b0;
      branchf_o    <= 1'b0;
      branchb_o    <= 1'b0;
      pc_advance_o <= 1'b0;
      case (state)
        S_FETCH: begin
          if (instr_ready_o && instr_valid_i) begin
            op_q                 <= in_op;
            alucontrol_o         <= dec_alu;
            rs_addr_o            <= dec_rs;
            rt_addr_o            <= dec_rt;
            write_addr_o         <= dec_wa;
            immediate_o          <= dec_imm;
            write_data_control_o <= dec_wdc;
            instr_ready_o        <= 1'b0;
            state                <= S_DECODE;
          end else begin
            instr_ready_o <= 1'b1;
          end
        end
        S_DECODE: begin
          if (op_q == OP_LOAD || op_q == OP_STORE) begin
            mem_req_o <= 1'b1;
            mem_we_o  <= (op_q == OP_STORE);
            mem_cnt   <= '0;
            state     <= S_MEM;
          end else if (op_q == OP_HALT) begin
            done_o <= 1'b1;
            state  <= S_HALT;
          end else begin
            regwrite_o   <= writes_reg;
            CBwrite_o    <= is_cb_write;
            branchf_o    <= (op_q == OP_BRF) && cb_i;
            branchb_o    <= (op_q == OP_BRB) && cb_i;
            pc_advance_o <= !(((op_q == OP_BRF) || (op_q == OP_BRB)) && cb_i);
            state        <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack_i) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_cnt      <= '0;
            regwrite_o   <= (op_q == OP_LOAD);
            pc_advance_o <= 1'b1;
            state        <= S_WB;
          end else begin
            mem_cnt <= mem_cnt + CNT_W'(1);
            if (mem_cnt == CNT_LAST) begin
              mem_req_o <= 1'b0;
              mem_we_o  <= 1'b0;
              err_o     <= 1'b1;
              state     <= S_ERROR;
            end
          end
        end
        S_WB: begin
          instr_ready_o <= 1'b1;
          state         <= S_FETCH;
        end
        S_HALT, S_ERROR: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: default 3-bit instance plus a
// 4-bit/ACC=15 instance for the parametrised seq case.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr;
  logic       instr_valid, cb, mem_ack;
  logic       instr_ready_o;
  logic [3:0] alucontrol_o;
  logic [2:0] rs_addr_o, rt_addr_o, write_addr_o;
  logic [4:0] immediate_o;
  logic       write_data_control_o, regwrite_o, CBwrite_o, mem_req_o, mem_we_o;
  logic       branchf_o, branchb_o, pc_advance_o, done_o, err_o;

  logic [8:0] instr2;
  logic       instr_valid2;
  logic       cb2 = 1'b0;
  logic       mem_ack2 = 1'b0;
  logic       instr_ready2;
  logic [3:0] alucontrol2;
  logic [3:0] rs_addr2, rt_addr2, write_addr2;
  logic [4:0] immediate2;
  logic       write_data_control2, regwrite2, CBwrite2, mem_req2, mem_we2;
  logic       branchf2, branchb2, pc_advance2, done2, err2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk_i(clk), .reset_i(reset), .instr_i(instr), .instr_valid_i(instr_valid),
    .instr_ready_o(instr_ready_o), .cb_i(cb), .alucontrol_o(alucontrol_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .write_addr_o(write_addr_o),
    .immediate_o(immediate_o), .write_data_control_o(write_data_control_o),
    .regwrite_o(regwrite_o), .CBwrite_o(CBwrite_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_ack_i(mem_ack), .branchf_o(branchf_o),
    .branchb_o(branchb_o), .pc_advance_o(pc_advance_o), .done_o(done_o), .err_o(err_o)
  );

  multicycle_control_fsm #(.REG_ADDR_W(4), .ACC_ADDR(15), .MEM_TIMEOUT(15)) dut4 (
    .clk_i(clk), .reset_i(reset), .instr_i(instr2), .instr_valid_i(instr_valid2),
    .instr_ready_o(instr_ready2), .cb_i(cb2), .alucontrol_o(alucontrol2),
    .rs_addr_o(rs_addr2), .rt_addr_o(rt_addr2), .write_addr_o(write_addr2),
    .immediate_o(immediate2), .write_data_control_o(write_data_control2),
    .regwrite_o(regwrite2), .CBwrite_o(CBwrite2), .mem_req_o(mem_req2),
    .mem_we_o(mem_we2), .mem_ack_i(mem_ack2), .branchf_o(branchf2),
    .branchb_o(branchb2), .pc_advance_o(pc_advance2), .done_o(done2), .err_o(err2)
  );

  task automatic applyStimulus(input logic [7:0] i, input logic v, input logic c, input logic a);
    instr       = i;
    instr_valid = v;
    cb          = c;
    mem_ack     = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic waitReady();
    for (int i = 0; i < 8 && instr_ready_o !== 1'b1; i++) @(negedge clk);
    checkOutput("ready_wait", instr_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(8'h00, 0, 0, 0);
    instr2 = '0;
    instr_valid2 = 1'b0;
    #12;
    checkOutput("rst_ready", instr_ready_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_req", mem_req_o, 0);
    checkOutput("rst_alu", alucontrol_o, 0);
    checkOutput("rst_pc", pc_advance_o, 0);
    @(negedge clk);
    reset = 1'b0;
    waitReady();

    // add r3 -> r2
    applyStimulus(8'b01_010_011, 1, 0, 0);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    checkOutput("add_alu", alucontrol_o, 4'b0001);
    checkOutput("add_rs", rs_addr_o, 3);
    checkOutput("add_rt", rt_addr_o, 7);
    checkOutput("add_wa", write_addr_o, 2);
    checkOutput("add_dec_ready", instr_ready_o, 0);
    checkOutput("add_dec_rw", regwrite_o, 0);
    @(negedge clk);
    checkOutput("add_wb_rw", regwrite_o, 1);
    checkOutput("add_wb_pc", pc_advance_o, 1);
    checkOutput("add_wb_cb", CBwrite_o, 0);
    checkOutput("add_wb_ready", instr_ready_o, 0);
    @(negedge clk);
    checkOutput("add_fetch_ready", instr_ready_o, 1);
    checkOutput("add_fetch_rw", regwrite_o, 0);
    checkOutput("add_fetch_pc", pc_advance_o, 0);

    // load r5, ack on the third MEM cycle
    applyStimulus(8'b10010_101, 1, 0, 0);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    checkOutput("ld_wa", write_addr_o, 5);
    checkOutput("ld_rt", rt_addr_o, 7);
    checkOutput("ld_rs", rs_addr_o, 0);
    checkOutput("ld_wdc", write_data_control_o, 1);
    checkOutput("ld_dec_req", mem_req_o, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("ld_mem_req", mem_req_o, 1);
      checkOutput("ld_mem_we", mem_we_o, 0);
      checkOutput("ld_mem_rw", regwrite_o, 0);
    end
    applyStimulus(8'h00, 0, 0, 1);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    checkOutput("ld_wb_req", mem_req_o, 0);
    checkOutput("ld_wb_rw", regwrite_o, 1);
    checkOutput("ld_wb_wdc", write_data_control_o, 1);
    checkOutput("ld_wb_wa", write_addr_o, 5);
    checkOutput("ld_wb_pc", pc_advance_o, 1);
    @(negedge clk);
    checkOutput("ld_fetch_ready", instr_ready_o, 1);

    // branchf taken: cb high during DECODE, low afterwards
    applyStimulus(8'b11110_001, 1, 0, 0);
    @(negedge clk);
    applyStimulus(8'h00, 0, 1, 0);
    checkOutput("bf_rs", rs_addr_o, 1);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    checkOutput("bf_t_branchf", branchf_o, 1);
    checkOutput("bf_t_pc", pc_advance_o, 0);
    checkOutput("bf_t_rw", regwrite_o, 0);
    checkOutput("bf_t_branchb", branchb_o, 0);
    @(negedge clk);
    checkOutput("bf_t_fetch_ready", instr_ready_o, 1);

    // branchf not taken
    applyStimulus(8'b11110_001, 1, 0, 0);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    @(negedge clk);
    checkOutput("bf_nt_branchf", branchf_o, 0);
    checkOutput("bf_nt_pc", pc_advance_o, 1);
    @(negedge clk);
    checkOutput("bf_nt_fetch_ready", instr_ready_o, 1);

    // branchb taken
    applyStimulus(8'b10110_010, 1, 0, 0);
    @(negedge clk);
    applyStimulus(8'h00, 0, 1, 0);
    checkOutput("bb_rs", rs_addr_o, 2);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    checkOutput("bb_branchb", branchb_o, 1);
    checkOutput("bb_branchf", branchf_o, 0);
    checkOutput("bb_pc", pc_advance_o, 0);
    @(negedge clk);

    // slt: fixed rs=6, CB write
    applyStimulus(8'b10000_000, 1, 0, 0);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    checkOutput("slt_alu", alucontrol_o, 4'b0101);
    checkOutput("slt_rs", rs_addr_o, 6);
    checkOutput("slt_rt", rt_addr_o, 7);
    checkOutput("slt_wa", write_addr_o, 0);
    @(negedge clk);
    checkOutput("slt_cbw", CBwrite_o, 1);
    checkOutput("slt_rw", regwrite_o, 0);
    checkOutput("slt_pc", pc_advance_o, 1);
    @(negedge clk);

    // subsigned r3
    applyStimulus(8'b11111_011, 1, 0, 0);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    checkOutput("sub_alu", alucontrol_o, 4'b0100);
    checkOutput("sub_rs", rs_addr_o, 2);
    checkOutput("sub_rt", rt_addr_o, 5);
    checkOutput("sub_wa", write_addr_o, 3);
    @(negedge clk);
    checkOutput("sub_rw", regwrite_o, 1);
    @(negedge clk);

    // set: immediate is the low five bits
    applyStimulus(8'b110_01_101, 1, 0, 0);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    checkOutput("set_alu", alucontrol_o, 4'b1000);
    checkOutput("set_imm", immediate_o, 5'd13);
    checkOutput("set_wa", write_addr_o, 7);
    checkOutput("set_rs", rs_addr_o, 0);
    @(negedge clk);
    checkOutput("set_rw", regwrite_o, 1);
    @(negedge clk);
    checkOutput("set_fetch_ready", instr_ready_o, 1);

    // store that never gets an ack
    applyStimulus(8'b10011_100, 1, 0, 0);
    @(negedge clk);
    applyStimulus(8'h00, 0, 0, 0);
    checkOutput("st_rs", rs_addr_o, 4);
    checkOutput("st_rt", rt_addr_o, 7);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checkOutput("st_mem_req", mem_req_o, 1);
      checkOutput("st_mem_we", mem_we_o, 1);
      checkOutput("st_mem_err", err_o, 0);
    end
    @(negedge clk);
    checkOutput("st_to_err", err_o, 1);
    checkOutput("st_to_req", mem_req_o, 0);
    checkOutput("st_to_ready", instr_ready_o, 0);
    applyStimulus(8'b01_010_011, 1, 0, 1);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", err_o, 1);
    checkOutput("err_ready", instr_ready_o, 0);
    checkOutput("err_rw", regwrite_o, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("err_rst_err", err_o, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(8'h00, 0, 0, 0);
    waitReady();

    // halt with valid held high afterwards
    applyStimulus(8'b10001_000, 1, 0, 0);
    @(negedge clk);
    checkOutput("halt_dec_done", done_o, 0);
    @(negedge clk);
    checkOutput("halt_done", done_o, 1);
    checkOutput("halt_ready", instr_ready_o, 0);
    repeat (3) @(negedge clk);
    checkOutput("halt_sticky", done_o, 1);
    checkOutput("halt_hold_ready", instr_ready_o, 0);
    checkOutput("halt_pc", pc_advance_o, 0);
    checkOutput("halt_rw", regwrite_o, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("halt_rst_done", done_o, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(8'h00, 0, 0, 0);

    // seq on the 4-bit instance
    for (int i = 0; i < 8 && instr_ready2 !== 1'b1; i++) @(negedge clk);
    checkOutput("w4_ready_wait", instr_ready2, 1);
    instr2 = 9'b10101_1010;
    instr_valid2 = 1'b1;
    @(negedge clk);
    instr_valid2 = 1'b0;
    checkOutput("w4_seq_alu", alucontrol2, 4'b0111);
    checkOutput("w4_seq_rs", rs_addr2, 10);
    checkOutput("w4_seq_rt", rt_addr2, 15);
    @(negedge clk);
    checkOutput("w4_seq_cbw", CBwrite2, 1);
    checkOutput("w4_seq_rw", regwrite2, 0);
    checkOutput("w4_seq_pc", pc_advance2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
